// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: opcode and FSM encodings plus the flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zf;
    logic cf;
    logic nf;
    logic vf;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: one result and four status flags per opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] r,
  output flags_t           flags
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] ext;

  // Result, carry/borrow and overflow per opcode; Z and N derive from the result.
  always_comb begin
    ext      = '0;
    r        = '0;
    flags    = '0;
    case (op)
      OP_ADD: begin
        ext      = {1'b0, a} + {1'b0, b};
        r        = ext[WIDTH-1:0];
        flags.cf = ext[WIDTH];
        flags.vf = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // Borrow out of the extended subtraction is exactly a < b unsigned.
        ext      = {1'b0, a} - {1'b0, b};
        r        = ext[WIDTH-1:0];
        flags.cf = ext[WIDTH];
        flags.vf = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin
        r        = {a[WIDTH-2:0], 1'b0};
        flags.cf = a[MSB];
      end
      OP_SHR: begin
        r        = {1'b0, a[WIDTH-1:1]};
        flags.cf = a[0];
      end
      default: r = '0;
    endcase
    flags.zf = (r == '0);
    flags.nf = r[MSB];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Runs a loadable table of ALU instructions, one per clock, with an optional
// accumulate path that feeds the previous result back as operand A.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 5,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    len,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [2:0]       prog_op,
  input  logic             prog_acc,
  input  logic [WIDTH-1:0] prog_a,
  input  logic [WIDTH-1:0] prog_b,
  output logic             busy,
  output logic             r_valid,
  output logic [AW-1:0]    step,
  output logic [WIDTH-1:0] R,
  output logic             ZF,
  output logic             CF,
  output logic             NF,
  output logic             VF,
  output logic             done
);

  state_e           state, state_nx;
  logic             run_en;
  logic [AW-1:0]    ptr, len_q;

  op_e              tbl_op  [DEPTH];
  logic             tbl_acc [DEPTH];
  logic [WIDTH-1:0] tbl_a   [DEPTH];
  logic [WIDTH-1:0] tbl_b   [DEPTH];

  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] alu_r;
  flags_t           alu_f;
  flags_t           flags_q;

  // Program table; writes only land while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_op[i]  <= OP_ADD;
        tbl_acc[i] <= 1'b0;
        tbl_a[i]   <= '0;
        tbl_b[i]   <= '0;
      end
    end else if (prog_we && (state == S_IDLE)) begin
      tbl_op[prog_addr]  <= op_e'(prog_op);
      tbl_acc[prog_addr] <= prog_acc;
      tbl_a[prog_addr]   <= prog_a;
      tbl_b[prog_addr]   <= prog_b;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (ptr == len_q) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy   = (state != S_IDLE);
    run_en = (state == S_RUN);
  end

  // Run length capture and step pointer; the pointer parks on the last step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      ptr   <= '0;
    end else if ((state == S_IDLE) && start) begin
      len_q <= len;
      ptr   <= '0;
    end else if (run_en && (ptr != len_q)) begin
      ptr   <= ptr + 1'b1;
    end
  end

  // Operand A: table value, or the previous result of this run (zero on step 0).
  always_comb begin
    opnd_a = tbl_a[ptr];
    if (tbl_acc[ptr]) opnd_a = (ptr == '0) ? '0 : R;
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a     (opnd_a),
    .b     (tbl_b[ptr]),
    .op    (tbl_op[ptr]),
    .r     (alu_r),
    .flags (alu_f)
  );

  // Registered result, flags and handshake pulses; results hold between runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      R       <= '0;
      flags_q <= '0;
      step    <= '0;
      r_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_valid <= run_en;
      done    <= (state == S_DONE);
      if (run_en) begin
        R       <= alu_r;
        flags_q <= alu_f;
        step    <= ptr;
      end
    end
  end

  assign ZF = flags_q.zf;
  assign CF = flags_q.cf;
  assign NF = flags_q.nf;
  assign VF = flags_q.vf;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed scenarios plus randomized programs
// checked against an arithmetic reference model.
module tb_alu_sequencer;

  localparam int W  = 5;
  localparam int D  = 8;
  localparam int AW = $clog2(D);
  localparam int M  = 1 << W;
  localparam int H  = 1 << (W - 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [2:0]    prog_op = '0;
  logic          prog_acc = 1'b0;
  logic [W-1:0]  prog_a = '0;
  logic [W-1:0]  prog_b = '0;
  logic          busy, r_valid, done;
  logic [AW-1:0] step;
  logic [W-1:0]  R;
  logic          ZF, CF, NF, VF;

  alu_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op),
    .prog_acc(prog_acc), .prog_a(prog_a), .prog_b(prog_b),
    .busy(busy), .r_valid(r_valid), .step(step), .R(R),
    .ZF(ZF), .CF(CF), .NF(NF), .VF(VF), .done(done)
  );

  always #5 clk = ~clk;

  // kind: 0 = another step follows, 1 = last step (done next), 2 = run aborted after this
  typedef struct {
    int stp; int r; int z; int c; int n; int v; int kind;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  bit   exp_v = 0, exp_d = 0, ev, ed;
  exp_t e;

  int m_op [D];
  int m_acc[D];
  int m_a  [D];
  int m_b  [D];

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= H) ? x - M : x;
  endfunction

  // Reference ALU written with plain integer arithmetic.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output int c, output int v);
    int s;
    c = 0; v = 0; r = 0;
    case (op)
      0: begin s = a + b; r = s % M; c = (s >= M);
               s = sgn(a) + sgn(b); v = (s >= H) || (s < -H); end
      1: begin r = (a - b + M) % M; c = (a < b);
               s = sgn(a) - sgn(b); v = (s >= H) || (s < -H); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (M - 1) - a;
      6: begin r = (a * 2) % M; c = (a >= H); end
      default: begin r = a / 2; c = a % 2; end
    endcase
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < D; i++) begin
      m_op[i] = 0; m_acc[i] = 0; m_a[i] = 0; m_b[i] = 0;
    end
  endfunction

  // Monitor: pops the scoreboard on every r_valid and checks pulse timing.
  always @(negedge clk) begin
    if (!reset) begin
      exp_v = 0; exp_d = 0;
    end else begin
      ev = exp_v; ed = exp_d; exp_v = 0; exp_d = 0;
      if (ev) check("no_bubble", r_valid, 1);
      if (done || ed) check("done_timing", done, ed);
      if (done) done_cnt++;
      if (r_valid) begin
        if (sb.size() == 0) check("spurious_r_valid", r_valid, 0);
        else begin
          e = sb.pop_front();
          check("step", step, e.stp);
          check("R",  R,  e.r);
          check("ZF", ZF, e.z);
          check("CF", CF, e.c);
          check("NF", NF, e.n);
          check("VF", VF, e.v);
          exp_v = (e.kind == 0);
          exp_d = (e.kind == 1);
        end
      end
    end
  end

  task automatic write_entry(input int addr, input int op, input int acc,
                             input int a, input int b);
    prog_addr = AW'(addr); prog_op = 3'(op); prog_acc = acc[0];
    prog_a = W'(a); prog_b = W'(b); prog_we = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0;
    m_op[addr] = op; m_acc[addr] = acc; m_a[addr] = a; m_b[addr] = b;
  endtask

  task automatic push_expected(input int ln, input int last_kind, input int upto);
    int prev, A, r, c, v;
    prev = 0;
    for (int i = 0; i <= upto; i++) begin
      A = (m_acc[i] != 0) ? ((i == 0) ? 0 : prev) : m_a[i];
      ref_alu(m_op[i], A, m_b[i], r, c, v);
      sb.push_back('{i, r, int'(r == 0), c, int'(r >= H), v,
                     (i == upto) ? last_kind : 0});
      prev = r;
    end
  endtask

  // One run of length ln+1; with hold, start and prog_we stay high until done.
  task automatic run(input int ln, input bit hold);
    int cyc, base;
    push_expected(ln, 1, ln);
    base = done_cnt;
    start = 1'b1; len = AW'(ln);
    @(posedge clk); #1;
    if (hold) begin
      prog_we = 1'b1; prog_addr = AW'($urandom_range(0, D - 1));
      prog_op = 3'($urandom); prog_acc = 1'($urandom);
      prog_a = W'($urandom); prog_b = W'($urandom);
    end else start = 1'b0;
    check("busy_after_start", busy, 1);
    check("no_result_yet", r_valid, 0);
    @(posedge clk); #1;
    check("first_latency", r_valid, 1);
    cyc = 0;
    while (done_cnt == base && cyc < 4 * D + 8) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("done_count", done_cnt - base, 1);
    start = 1'b0; prog_we = 1'b0;
    check("busy_with_done", busy, 0);
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_R"}, R, 0);
    check({tag, "_flags"}, {ZF, CF, NF, VF}, 0);
    check({tag, "_r_valid"}, r_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_step"}, step, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    #1 check_zeroed("reset_idle");
    @(posedge clk); #1 reset = 1'b1;

    // Unprogrammed table: ADD 0+0.
    run(0, 0);
    check("unprog_ZF", ZF, 1);

    // ADD 7+9 then SUB 3-5.
    write_entry(0, 0, 0, 7, 9);
    write_entry(1, 1, 0, 3, 5);
    run(1, 0);
    check("sub_R", R, 30);
    check("sub_CF", CF, 1);
    check("sub_VF", VF, 0);

    // Reset mid-idle clears held results and the table.
    @(negedge clk); #1 reset = 1'b0; clear_model();
    #1 check_zeroed("reset_held");
    @(posedge clk); #1 reset = 1'b1;

    // Wrap-around ADD and SHL shifting out the top bit.
    write_entry(0, 0, 0, 31, 1);
    write_entry(1, 6, 0, 17, 0);
    run(1, 0);
    check("shl_R", R, 2);
    check("shl_CF", CF, 1);

    // Accumulate chain 0+4, <<1, -3.
    write_entry(0, 0, 1, 21, 4);
    write_entry(1, 6, 1, 9, 0);
    write_entry(2, 1, 1, 30, 3);
    run(2, 0);
    check("acc_R", R, 5);
    check("acc_step", step, 2);

    // start and prog_we held through a run; table must be unchanged afterwards.
    write_entry(3, 4, 1, 0, 13);
    run(3, 1);
    @(posedge clk); #1;
    check("no_rerun", busy, 0);
    run(3, 0);

    // Reset while step 2 is executing.
    for (int i = 0; i < D; i++)
      write_entry(i, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, M - 1), $urandom_range(0, M - 1));
    push_expected(D - 1, 2, 1);
    start = 1'b1; len = AW'(D - 1);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1 reset = 1'b0; clear_model();
    #1 check_zeroed("reset_run");
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < D; i++)
      write_entry(i, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, M - 1), $urandom_range(0, M - 1));
    run(D - 1, 0);

    // Randomized programs and run lengths, back-to-back where possible.
    for (int it = 0; it < 30; it++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--)
        write_entry($urandom_range(0, D - 1), $urandom_range(0, 7), $urandom_range(0, 1),
                    $urandom_range(0, M - 1), $urandom_range(0, M - 1));
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
      #1 run($urandom_range(0, D - 1), 0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Parametrised successor to the fixed 5-bit FSM+ALU top. It executes a loadable program of up to DEPTH ALU instructions, one per clock, and registers the result and four status flags for each step. Each instruction can chain on the previous result through an accumulate bit. It sits at the same level as the existing top: a program is written through a write port, `start` launches a run, and `done` reports completion.

## Interface
- WIDTH, 5, operand/result width (≥2)
- DEPTH, 8, program table entries (power of two, ≥2); AW = $clog2(DEPTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch run; sampled only in IDLE
- len  in  AW  run length minus one; sampled with start
- prog_we  in  1  write program entry; ignored while busy
- prog_addr  in  AW  entry index
- prog_op  in  3  opcode
- prog_acc  in  1  1 = operand A is previous result
- prog_a, prog_b  in  WIDTH  operands
- busy  out  1  state ≠ IDLE
- r_valid  out  1  one-cycle pulse per completed step
- step  out  AW  index of step reported with r_valid
- R  out  WIDTH  registered result
- ZF, CF, NF, VF  out  1  registered flags
- done  out  1  one-cycle pulse after the last step

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical).
- Operand A = prog_a, or, if acc=1, the previous step's R in the same run. For step 0 with acc=1, operand A = 0.
- Flags:
  - ZF = (R==0).
  - NF = R[WIDTH-1].
  - CF = carry-out for ADD; borrow (A<B unsigned) for SUB; bit shifted out for SHL/SHR; 0 otherwise.
  - VF = signed overflow for ADD/SUB; 0 otherwise.
- Results are truncated to WIDTH bits.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1. len is latched and the step pointer is cleared.
  - RUN executes entry[ptr] each cycle and increments ptr. After ptr==len_q it goes to DONE.
  - DONE → IDLE unconditionally.
- start is ignored in RUN and DONE. prog_we is ignored when busy.
- R and the flags hold their values between runs.
- Reset (async, any state) clears:
  - state to IDLE;
  - R, all flags, r_valid, done, step, busy and ptr to 0;
  - every table entry to all-zero (ADD, acc 0, 0, 0).

## Timing
- Program write takes effect at the clk edge with prog_we=1. The entry is readable in the next cycle.
- Start accepted at edge k:
  - step i result is on R/flags with r_valid=1 and step=i after edge k+1+i;
  - done=1 during the cycle after edge k+len+2;
  - busy=1 from after edge k through the DONE cycle;
  - a new start is accepted at edge k+len+3 at the earliest.
- len=DEPTH−1 runs every entry. ptr never wraps.
- The table is read combinationally, so each result has one cycle of latency and there are no bubbles.

## Structure
- Package `alu_pkg`:
  - `op_e` opcode enum (3 bits);
  - `state_e` FSM enum;
  - `flags_t` packed struct {zf, cf, nf, vf}.
- Sub-module `alu_core #(WIDTH)`: purely combinational (a, b, op) → (r, flags_t). It is reused by `alu_sequencer`.
- `alu_sequencer` holds the table register array, the FSM, the pointer, the accumulate mux and the output registers.

## Test plan
- Reset values: assert reset mid-idle → all outputs 0, busy=0. Then run len=0 without programming → R=0, ZF=1, CF=0.
- ADD and SUB at WIDTH=5:
  - entry0 ADD 7+9, entry1 SUB 3−5; start with len=1;
  - cycle 1: R=16, CF=0, NF=1, VF=1;
  - cycle 2: R=30, CF=1, NF=1, VF=0;
  - done pulses on the cycle after, then busy=0.
- Wrap: ADD 31+1 → R=0, ZF=1, CF=1, VF=0. SHL 5'b10001 → R=5'b00010, CF=1.
- Accumulate chain:
  - entries ADD acc 0+4; SHL acc; SUB acc B=3;
  - results 4, 8, 5, with step=0,1,2 on consecutive cycles.
- Collisions: start and prog_we held high throughout a len=3 run → exactly one run (4 r_valid pulses, one done) and the table is unchanged. Asserting reset at step 2 → immediate IDLE and zeroed outputs; a later run of the reprogrammed table is correct.
- WIDTH=8, DEPTH=4: ADD 127+1 → R=128, VF=1, NF=1, CF=0. len=3 runs all 4 entries with step 0..3.
